// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESC_W = 6;
    localparam int unsigned EDGE_W  = 5;

    localparam logic [PRESC_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESC_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESC_W-1:0] PRESCALE_32 = 6'd32;

    function automatic logic prescale_ok(input logic [PRESC_W-1:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter; bit_end marks the last edge of a bit.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int unsigned BIT_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] prescale_l,
    output logic [EDGE_W-1:0]  edge_count,
    output logic [BIT_W-1:0]   bit_count,
    output logic               bit_end
);

    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]  bit_q, bit_d;

    assign bit_end    = enable && ({1'b0, edge_q} == (prescale_l - 6'd1));
    assign edge_count = edge_q;
    assign bit_count  = bit_q;

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clear) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (enable) begin
            if (bit_end) begin
                edge_d = '0;
                bit_d  = bit_q + 1'b1;
            end else begin
                edge_d = edge_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, deserialise, parity/stop check, word delivery.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [4:0]            edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 3);

    rx_state_e             state_q, state_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  start_det;
    logic                  cnt_en;
    logic                  bit_end;
    logic [BIT_W-1:0]      bit_count;
    logic                  exp_par;

    assign start_det = (state_q == IDLE) && !RX_IN;
    assign cnt_en    = (state_q != IDLE);

    uart_rx_edge_bit_cnt #(
        .BIT_W(BIT_W)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (cnt_en),
        .clear     (start_det),
        .prescale_l(presc_q),
        .edge_count(edge_count),
        .bit_count (bit_count),
        .bit_end   (bit_end)
    );

    assign exp_par = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    // unsupported ratios fall back to 16 so the 5-bit edge counter cannot overrun
                    presc_d   = prescale_ok(Prescale) ? Prescale : PRESCALE_16;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    // bit_count is 1 during the first data bit, since START also counted
                    if (bit_count == BIT_W'(DATA_WIDTH)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_err_d = (sampled_bit != exp_par);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stp_err_d = ~sampled_bit;
                    state_d   = IDLE;
                    if (sampled_bit && !par_err_q) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            shift_q   <= '0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign dat_samp_en = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign P_DATA      = pdata_q;
    assign data_valid  = dv_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: vector table, hand-written corner sequences and random frames vs a frame-level model.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic [4:0] edge_count;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int samp_p = 8;

    logic [7:0] dvq_data[$];
    int         dvq_cyc[$];
    logic       prev_dv = 1'b0;
    logic       v0, v1;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .sampled_bit(sampled_bit),
        .dat_samp_en(dat_samp_en),
        .edge_count (edge_count),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural 3-tap majority sampler around mid-bit of the frame's own ratio
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit <= 1'b1;
            v0 <= 1'b1;
            v1 <= 1'b1;
        end else if (dat_samp_en) begin
            if (int'(edge_count) == samp_p / 2 - 1) v0 <= RX_IN;
            if (int'(edge_count) == samp_p / 2)     v1 <= RX_IN;
            if (int'(edge_count) == samp_p / 2 + 1)
                sampled_bit <= (v0 & v1) | (v0 & RX_IN) | (v1 & RX_IN);
        end
    end

    always @(negedge CLK) begin
        if (data_valid) begin
            if (prev_dv) chk("dv_one_cycle", 32'd1, 32'd0);
            chk("busy_at_dv", 32'(busy), 32'd0);
            dvq_data.push_back(P_DATA);
            dvq_cyc.push_back(cyc);
        end
        prev_dv <= data_valid;
    end

    task automatic send_frame(input int p, input bit pe, input bit typ, input logic [7:0] data,
                              input bit pbit, input bit stop, input int alt_p, input int gap,
                              output int s);
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = typ;
        samp_p   = p;
        s        = cyc;
        RX_IN    = 1'b0;
        repeat (p) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            if (alt_p != 0 && i == 2) begin
                Prescale = 6'(alt_p);
                PAR_EN   = !pe;
                PAR_TYP  = !typ;
            end
            if (i == 6) begin
                Prescale = 6'(p);
                PAR_EN   = pe;
                PAR_TYP  = typ;
            end
            RX_IN = data[i];
            repeat (p) @(negedge CLK);
        end
        if (pe) begin
            RX_IN = pbit;
            repeat (p) @(negedge CLK);
        end
        RX_IN = stop;
        repeat (p) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic check_frame(input string nm, input int s, input int nbits, input int p,
                               input bit valid, input logic [7:0] pdata, input bit perr, input bit serr);
        chk({nm, "_dv_count"}, 32'(dvq_data.size()), valid ? 32'd1 : 32'd0);
        if (valid && dvq_data.size() > 0) begin
            chk({nm, "_dv_word"}, 32'(dvq_data[0]), 32'(pdata));
            chk({nm, "_dv_cycle"}, 32'(dvq_cyc[0]), 32'(s + 1 + nbits * p));
        end
        dvq_data.delete();
        dvq_cyc.delete();
        chk({nm, "_P_DATA"}, 32'(P_DATA), 32'(pdata));
        chk({nm, "_par_err"}, 32'(par_err), 32'(perr));
        chk({nm, "_stp_err"}, 32'(stp_err), 32'(serr));
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_samp_en"}, 32'(dat_samp_en), 32'd0);
    endtask

    typedef struct {
        int         p;
        bit         pe;
        bit         typ;
        logic [7:0] data;
        bit         pbit;
        bit         stop;
        bit         valid;
        logic [7:0] pdata;
        bit         perr;
        bit         serr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2;
        int plist[3];
        logic [7:0] model_pdata;
        plist = '{8, 16, 32};

        vecs[0] = '{8,  0, 0, 8'hA5, 0, 1, 1, 8'hA5, 0, 0};
        vecs[1] = '{16, 1, 0, 8'h3C, 0, 1, 1, 8'h3C, 0, 0};
        vecs[2] = '{16, 1, 0, 8'h3C, 1, 1, 0, 8'h3C, 1, 0};
        vecs[3] = '{32, 1, 1, 8'h01, 0, 0, 0, 8'h3C, 0, 1};
        vecs[4] = '{8,  1, 1, 8'hFF, 1, 1, 1, 8'hFF, 0, 0};
        vecs[5] = '{32, 0, 0, 8'h00, 0, 1, 1, 8'h00, 0, 0};
        vecs[6] = '{8,  0, 1, 8'h5A, 1, 0, 0, 8'h00, 0, 1};

        RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_samp_en", 32'(dat_samp_en), 32'd0);
        chk("rst_edge", 32'(edge_count), 32'd0);
        chk("rst_pdata", 32'(P_DATA), 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_par", 32'(par_err), 32'd0);
        chk("rst_stp", 32'(stp_err), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].p, vecs[i].pe, vecs[i].typ, vecs[i].data, vecs[i].pbit,
                       vecs[i].stop, 0, 3, s);
            check_frame($sformatf("vec%0d", i), s, 10 + int'(vecs[i].pe), vecs[i].p,
                        vecs[i].valid, vecs[i].pdata, vecs[i].perr, vecs[i].serr);
        end
        model_pdata = 8'h00;

        // Start glitch: low for 3 cycles at Prescale 8
        Prescale = 6'd8; PAR_EN = 1'b0; samp_p = 8;
        s = cyc;
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        while (cyc < s + 8) @(negedge CLK);
        chk("glitch_busy_edge7", 32'(busy), 32'd1);
        chk("glitch_edge7", 32'(edge_count), 32'd7);
        @(negedge CLK);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_samp_en", 32'(dat_samp_en), 32'd0);
        chk("glitch_par", 32'(par_err), 32'd0);
        chk("glitch_stp", 32'(stp_err), 32'd0);
        chk("glitch_pdata", 32'(P_DATA), 32'(model_pdata));
        chk("glitch_no_dv", 32'(dvq_data.size()), 32'd0);
        repeat (3) @(negedge CLK);

        // Back-to-back 8N1 frames, Prescale disturbed mid-way through the first
        send_frame(16, 0, 0, 8'h55, 0, 1, 8, 0, s);
        send_frame(16, 0, 0, 8'hAA, 0, 1, 0, 4, s2);
        chk("b2b_dv_count", 32'(dvq_data.size()), 32'd2);
        if (dvq_data.size() == 2) begin
            chk("b2b_word0", 32'(dvq_data[0]), 32'h55);
            chk("b2b_word1", 32'(dvq_data[1]), 32'hAA);
            chk("b2b_spacing_ok", 32'((dvq_cyc[1] - dvq_cyc[0] >= 159) && (dvq_cyc[1] - dvq_cyc[0] <= 161)), 32'd1);
        end
        dvq_data.delete(); dvq_cyc.delete();
        model_pdata = 8'hAA;
        chk("b2b_pdata", 32'(P_DATA), 32'(model_pdata));

        // Reset during data bit 4
        Prescale = 6'd16; PAR_EN = 1'b0; samp_p = 16;
        RX_IN = 1'b0;
        repeat (16) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = i[0];
            repeat (16) @(negedge CLK);
        end
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        chk("rstmid_busy_before", 32'(busy), 32'd1);
        RST = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_samp_en", 32'(dat_samp_en), 32'd0);
        chk("rstmid_edge", 32'(edge_count), 32'd0);
        chk("rstmid_pdata", 32'(P_DATA), 32'd0);
        chk("rstmid_dv", 32'(data_valid), 32'd0);
        chk("rstmid_flags", 32'({par_err, stp_err}), 32'd0);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rstmid_no_dv", 32'(dvq_data.size()), 32'd0);
        send_frame(16, 0, 0, 8'h7E, 0, 1, 0, 3, s);
        model_pdata = 8'h7E;
        check_frame("after_rst", s, 10, 16, 1, model_pdata, 0, 0);

        // Random frames against a frame-level model
        for (int n = 0; n < 24; n++) begin
            int p, alt, gap, ones;
            bit pe, typ, pbit, stop, par_ok, valid;
            logic [7:0] data;
            p    = plist[$urandom_range(0, 2)];
            alt  = ($urandom_range(0, 1) != 0) ? plist[$urandom_range(0, 2)] : 0;
            gap  = $urandom_range(3, 6);
            pe   = 1'($urandom_range(0, 1));
            typ  = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            data = 8'($urandom);
            ones   = $countones(data) + int'(pbit);
            par_ok = !pe || ((ones % 2) == (typ ? 1 : 0));
            valid  = par_ok && stop;
            if (valid) model_pdata = data;
            send_frame(p, pe, typ, data, pbit, stop, alt, gap, s);
            check_frame($sformatf("rand%0d", n), s, 10 + int'(pe), p, valid, model_pdata,
                        !par_ok, !stop);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
